pwm_channel_bank: RTL and testbench

- Multi-channel PWM core in the PWM clock domain, directly downstream of the Avalon-MM register slave.
- Consumes the slave's Ton, nLatch and oe registers and drives NB_PWM PWM outputs from one shared free-running period counter.
- Each channel has a double-buffered duty: a shadow register loaded from the bus, and an active register committed only at period wrap, so outputs are glitch-free.

---
 rtl/pwm_channel_bank.sv | 99 +++++++++
 tb/tb_pwm_channel_bank.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_channel_bank.sv
// pwm_channel_bank: NB_PWM in-phase PWM channels sharing one period counter.
// Duty is double-buffered: shadow loads from the bus, active commits at wrap.
module pwm_channel_bank #(
    parameter int NB_PWM     = 24,
    parameter int RESOLUTION = 10
) (
    input  logic                  clk_pwm,
    input  logic                  reset_n,
    input  logic [RESOLUTION-1:0] ton,
    input  logic [NB_PWM-1:0]     n_latch,
    input  logic [NB_PWM-1:0]     oe,
    output logic [NB_PWM-1:0]     pwm,
    output logic                  period_start
);

    localparam logic [RESOLUTION-1:0] CNT_MAX = '1;
    localparam logic [RESOLUTION-1:0] CNT_ONE = RESOLUTION'(1);

    logic [RESOLUTION-1:0] ton_m_q, ton_m_d;
    logic [RESOLUTION-1:0] ton_s_q, ton_s_d;
    logic [NB_PWM-1:0]     nl_m_q, nl_m_d;
    logic [NB_PWM-1:0]     nl_s_q, nl_s_d;
    logic [NB_PWM-1:0]     oe_m_q, oe_m_d;
    logic [NB_PWM-1:0]     oe_s_q, oe_s_d;

    logic                  run_q, run_d;
    logic [RESOLUTION-1:0] cnt_q, cnt_d;
    logic                  wrap;

    logic [NB_PWM-1:0][RESOLUTION-1:0] shadow_q, shadow_d;
    logic [NB_PWM-1:0][RESOLUTION-1:0] active_q, active_d;

    logic [NB_PWM-1:0]     pwm_q, pwm_d;
    logic                  period_start_q, period_start_d;

    always_comb begin
        ton_m_d = ton;
        ton_s_d = ton_m_q;
        nl_m_d  = n_latch;
        nl_s_d  = nl_m_q;
        oe_m_d  = oe;
        oe_s_d  = oe_m_q;

        // run_q keeps cnt at 0 on the first edge after release,
        // so a fresh period starts right there.
        run_d = 1'b1;
        cnt_d = run_q ? cnt_q + CNT_ONE : '0;
        wrap  = (cnt_q == CNT_MAX);

        shadow_d = shadow_q;
        active_d = active_q;
        pwm_d    = '0;
        for (int i = 0; i < NB_PWM; i++) begin
            if (!nl_s_q[i]) begin
                shadow_d[i] = ton_s_q;
            end
            if (wrap) begin
                active_d[i] = shadow_q[i];
            end
            pwm_d[i] = oe_s_q[i] & (cnt_d < active_d[i]);
        end

        period_start_d = (cnt_d == '0);
    end

    always_ff @(posedge clk_pwm) begin
        if (!reset_n) begin
            ton_m_q        <= '0;
            ton_s_q        <= '0;
            nl_m_q         <= '1;
            nl_s_q         <= '1;
            oe_m_q         <= '0;
            oe_s_q         <= '0;
            run_q          <= 1'b0;
            cnt_q          <= '0;
            shadow_q       <= '0;
            active_q       <= '0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            ton_m_q        <= ton_m_d;
            ton_s_q        <= ton_s_d;
            nl_m_q         <= nl_m_d;
            nl_s_q         <= nl_s_d;
            oe_m_q         <= oe_m_d;
            oe_s_q         <= oe_s_d;
            run_q          <= run_d;
            cnt_q          <= cnt_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm          = pwm_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_channel_bank.sv
// tb_pwm_channel_bank: scoreboard bench for pwm_channel_bank (4 ch, 4-bit).
// A period-level reference model predicts every registered output cycle.
module tb_pwm_channel_bank;

    localparam int NB  = 4;
    localparam int RES = 4;
    localparam int P   = 1 << RES;

    logic           clk_pwm = 1'b0;
    logic           reset_n;
    logic [RES-1:0] ton;
    logic [NB-1:0]  n_latch;
    logic [NB-1:0]  oe;
    logic [NB-1:0]  pwm;
    logic           period_start;

    always #5 clk_pwm = ~clk_pwm;

    pwm_channel_bank #(
        .NB_PWM    (NB),
        .RESOLUTION(RES)
    ) dut (
        .clk_pwm     (clk_pwm),
        .reset_n     (reset_n),
        .ton         (ton),
        .n_latch     (n_latch),
        .oe          (oe),
        .pwm         (pwm),
        .period_start(period_start)
    );

    typedef struct packed {
        logic [NB-1:0] pwm;
        logic          ps;
    } exp_t;

    typedef struct packed {
        logic [RES-1:0] t;
        logic [NB-1:0]  nl;
        logic [NB-1:0]  o;
    } in_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: inputs become visible two edges after they are
    // sampled; a period is P edges long, starting on the first edge
    // after reset release; duty is what the shadow held at the period end.
    in_t  pipe[$];
    int   phase;
    int   shadow[NB];
    int   duty[NB];

    logic [RES-1:0] h_ton;
    logic [NB-1:0]  h_nl;
    logic [NB-1:0]  h_oe;

    function automatic void model_reset();
        pipe.delete();
        pipe.push_back('{t: '0, nl: '1, o: '0});
        pipe.push_back('{t: '0, nl: '1, o: '0});
        phase = -1;
        for (int i = 0; i < NB; i++) begin
            shadow[i] = 0;
            duty[i]   = 0;
        end
    endfunction

    task automatic step(input logic rst);
        in_t  seen;
        exp_t e;
        @(negedge clk_pwm);
        ton     = h_ton;
        n_latch = h_nl;
        oe      = h_oe;
        reset_n = rst;
        e       = '0;
        if (!rst) begin
            model_reset();
        end else begin
            seen = pipe.pop_front();
            if (phase == P - 1) begin
                for (int i = 0; i < NB; i++) duty[i] = shadow[i];
            end
            for (int i = 0; i < NB; i++) begin
                if (!seen.nl[i]) shadow[i] = int'(seen.t);
            end
            phase = (phase + 1) % P;
            pipe.push_back('{t: h_ton, nl: h_nl, o: h_oe});
            for (int i = 0; i < NB; i++) begin
                e.pwm[i] = seen.o[i] && (phase < duty[i]);
            end
            e.ps = (phase == 0);
        end
        sb_q.push_back(e);
        cyc++;
    endtask

    task automatic hold(input int n);
        repeat (n) step(1'b1);
    endtask

    task automatic wait_phase(input int k);
        for (int j = 0; j < P + 2 && phase != k; j++) hold(1);
    endtask

    task automatic load(input logic [NB-1:0] mask, input logic [RES-1:0] v);
        h_ton = v;
        h_nl  = '1;
        hold(3);
        h_nl = mask;
        hold(4);
        h_nl = '1;
        hold(3);
    endtask

    // Counts high cycles of one channel over one aligned period.
    task automatic count_high(input int ch, input int exp_n,
                              input string name);
        int h;
        wait_phase(P - 1);
        h = 0;
        repeat (P) begin
            hold(1);
            @(posedge clk_pwm);
            #2;
            if (pwm[ch] === 1'b1) h++;
        end
        checks++;
        if (h != exp_n) begin
            errors++;
            $display("FAIL %s: ch%0d high %0d cycles, expected %0d",
                     name, ch, h, exp_n);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_pwm);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (pwm !== e.pwm || period_start !== e.ps) begin
                    errors++;
                    $display("FAIL out@%0t: pwm=%b ps=%b, expected pwm=%b ps=%b",
                             $time, pwm, period_start, e.pwm, e.ps);
                end
            end
        end
    end

    initial begin : stim
        reset_n = 1'b0;
        ton     = '0;
        n_latch = '1;
        oe      = '0;
        h_ton   = '0;
        h_nl    = '1;
        h_oe    = '0;
        model_reset();

        // reset and idle
        repeat (3) step(1'b0);
        hold(40);

        // basic duty
        h_oe = 4'b0001;
        load(4'b1110, 4'd5);
        count_high(0, 5, "basic_ch0");
        count_high(1, 0, "basic_ch1");

        // double buffering: reload at mid period
        h_ton = 4'd12;
        hold(3);
        wait_phase(6);
        h_nl = 4'b1110;
        hold(4);
        h_nl = '1;
        hold(2);
        count_high(0, 12, "dbuf_next");

        // boundary duties
        load(4'b1110, 4'd0);
        count_high(0, 0, "duty_zero");
        load(4'b1110, 4'd15);
        count_high(0, 15, "duty_max");

        // load on the wrap edge
        load(4'b1110, 4'd3);
        count_high(0, 3, "wrap_pre");
        h_ton = 4'd9;
        hold(3);
        wait_phase(13);
        h_nl = 4'b1110;
        hold(1);
        h_nl = '1;
        hold(1);
        count_high(0, 3, "wrap_old");
        count_high(0, 9, "wrap_new");

        // oe gating and independence
        load(4'b1110, 4'd4);
        load(4'b1101, 4'd10);
        h_oe = 4'b0011;
        hold(3);
        count_high(1, 10, "oe_ch1_on");
        wait_phase(6);
        h_oe = 4'b0001;
        hold(20);
        count_high(1, 0, "oe_ch1_off");
        count_high(0, 4, "oe_ch0_kept");
        h_oe = 4'b0011;
        hold(3);
        count_high(1, 10, "oe_ch1_back");

        // reset mid-period
        wait_phase(7);
        repeat (2) step(1'b0);
        hold(20);

        // randomized traffic
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 9) == 0) h_ton = RES'($urandom);
            h_nl = ($urandom_range(0, 7) == 0) ? NB'($urandom) : '1;
            if ($urandom_range(0, 19) == 0) h_oe = NB'($urandom);
            step(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1);
        end

        h_nl = '1;
        hold(2);
        repeat (3) @(posedge clk_pwm);
        #3;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected outputs left, expected 0",
                     sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
